alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Sequential issue and decode front-end for the 5-bit-control ALU. It accepts one 32-bit MIPS instruction through a valid/ready handshake and reads register operands. It drives the ALU's src1/src2/ctrl inputs from registers, then captures the ALU's result, zero and overflow outputs. It returns a writeback packet with error flags through a second valid/ready handshake. It sits between instruction fetch/register file and the ALU.

Parameters:
DW, 32, datapath width (fixed at 32; the ALU is 32-bit)
CNTW, 32, width of the retired-instruction counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
in_valid_i  in  1  instruction valid
in_ready_o  out  1  block can accept an instruction
instr_i  in  32  instruction word
rs_addr_o  out  5  register-file read address, instr[25:21] of the latched instruction
rt_addr_o  out  5  register-file read address, instr[20:16] of the latched instruction
rs_data_i  in  32  rs read data, combinational from register file
rt_data_i  in  32  rt read data
alu_src1_o  out  32  registered ALU src1
alu_src2_o  out  32  registered ALU src2
alu_ctrl_o  out  5  registered ALU control code
alu_result_i  in  32  ALU result
alu_zero_i  in  1  ALU zero/compare output
alu_err_i  in  1  ALU signed-overflow output
out_valid_o  out  1  writeback packet valid
out_ready_i  in  1  consumer accepts the packet
res_o  out  32  captured ALU result
zero_o  out  1  captured zero/branch condition
ovf_o  out  1  captured overflow
wb_en_o  out  1  register write required
wb_addr_o  out  5  destination register
w0_err_o  out  1  write to $0 attempted; instruction is not the exact NOP 0x00000000
illegal_o  out  1  unknown opcode/funct
retired_o  out  CNTW  count of packets accepted on the output side

Behaviour:
- Reset: all outputs 0 except in_ready_o; state IDLE; retired_o 0.
- in_ready_o = 1 in IDLE, and in DONE when out_ready_i = 1.
- Reset mid-operation aborts the instruction in flight; nothing is emitted.
- FSM:
  - IDLE: on in_valid_i & in_ready_o, latch instr_i, go to DECODE.
  - DECODE: drive rs/rt addresses; at the clock edge register alu_src1/src2/ctrl; go to EXEC.
  - EXEC: the ALU settles; at the clock edge capture result/zero/err into res_o/zero_o/ovf_o; go to DONE.
  - DONE: out_valid_o = 1. All outputs hold stable until out_ready_i. On the handshake, retired_o increments (wraps modulo 2^CNTW). Then go to DECODE if a new instruction is accepted in the same cycle, else to IDLE.
- Latency: instruction accepted in cycle 0 gives out_valid_o in cycle 3. Back-to-back throughput is one instruction per 3 cycles.
- Control decode (ctrl code in decimal):
  - R-type (opcode 0x00), by funct: add 0x20→1, addu 0x21→2, sub 0x22→3, and 0x24→4, or 0x25→5, xor 0x26→6, nor 0x27→7, nand 0x28→8, slt 0x2A→9, sll 0x00→10, srl 0x02→11, sra 0x03→18, jr 0x08→12.
  - I/J-type, by opcode: addi 0x08→1, addiu 0x09→2, lw/lh/lhu/lb/lbu/sw/sh/sb (0x23, 0x21, 0x25, 0x20, 0x24, 0x2B, 0x29, 0x28)→1, lui 0x0F→17, andi 0x0C→20, ori 0x0D→19, nori 0x0E→21, slti 0x0A→9, beq 0x04→13, bne 0x05→14, bgtz 0x07→15, j 0x02 / jal 0x03→16, halt 0x3F→0.
  - Anything else: ctrl 0, illegal_o = 1, wb_en_o = 0.
- Operands:
  - Shifts (sll/srl/sra): src1 = zero-extended shamt instr[10:6]; src2 = rt_data.
  - Other R-types and beq/bne/bgtz: src1 = rs_data; src2 = rt_data.
  - Other I-types: src1 = rs_data; src2 = sign-extended imm[15:0]. The ALU itself masks the immediate for andi/ori/nori.
  - j/jal/halt: src1 = src2 = 0.
- Writeback target:
  - R-type (except jr) → rd.
  - addi, addiu, loads, lui, andi, ori, nori, slti → rt.
  - jal → 31.
  - Stores, branches, jr, j, halt, illegal → no write.
- wb_en_o = write-type AND target ≠ 0.
- w0_err_o = write-type AND target = 0 AND instr ≠ 0x00000000.
- Overflow does not suppress wb_en_o; ovf_o is reported alongside the write.

Test Plan:
1. add $3,$1,$2 (0x00221820), rs_data = 0x7FFFFFFF, rt_data = 1 → ctrl 1, res_o 0x80000000, ovf_o 1, wb_en_o 1, wb_addr_o 3; out_valid_o rises exactly 3 cycles after accept.
2. addi $5,$0,-1 (0x2005FFFF), rs_data = 0 → src2 0xFFFFFFFF, res_o 0xFFFFFFFF, ovf_o 0, wb_addr_o 5.
3. sll $4,$2,3 (0x000220C0), rt_data = 5 → src1 3, ctrl 10, res_o 40; then NOP 0x00000000 → wb_en_o 0, w0_err_o 0.
4. beq $1,$2 (0x10220004), rs_data = rt_data = 7 → ctrl 13, zero_o 1, wb_en_o 0; add $0,$1,$2 (0x00220020) → w0_err_o 1, wb_en_o 0.
5. Opcode 0x3E (0xF8000000) → illegal_o 1, ctrl 0; out_ready_i held low 5 cycles → all outputs stable, in_ready_o 0, retired_o unchanged until the handshake.
6. rst_i asserted during EXEC → next cycle IDLE, out_valid_o 0, retired_o 0; a following instruction completes normally.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/decode front-end for the 5-bit-control ALU: latches one MIPS instruction,
// drives registered ALU operands, captures the ALU outputs and returns a writeback packet.
module alu_issue_ctrl #(
   parameter int DW   = 32,
   parameter int CNTW = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   output logic [4:0]      rs_addr_o,
   output logic [4:0]      rt_addr_o,
   input  logic [DW-1:0]   rs_data_i,
   input  logic [DW-1:0]   rt_data_i,
   output logic [DW-1:0]   alu_src1_o,
   output logic [DW-1:0]   alu_src2_o,
   output logic [4:0]      alu_ctrl_o,
   input  logic [DW-1:0]   alu_result_i,
   input  logic            alu_zero_i,
   input  logic            alu_err_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [DW-1:0]   res_o,
   output logic            zero_o,
   output logic            ovf_o,
   output logic            wb_en_o,
   output logic [4:0]      wb_addr_o,
   output logic            w0_err_o,
   output logic            illegal_o,
   output logic [CNTW-1:0] retired_o
);

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, DONE} state_t;
   typedef enum logic [1:0] {OPS_ZERO, OPS_SHAMT, OPS_RR, OPS_RI} opsel_t;

   typedef struct packed {
      logic [4:0] ctrl;
      opsel_t     opsel;
      logic       wr;
      logic [4:0] tgt;
      logic       illegal;
   } dec_t;

   state_t        state, state_nxt;
   logic [31:0]   instr_q;
   dec_t          dec;
   logic [5:0]    op, fn;
   logic [DW-1:0] src1_d, src2_d;
   logic          accept, wb_en_d, w0_err_d;

   assign op        = instr_q[31:26];
   assign fn        = instr_q[5:0];
   assign rs_addr_o = instr_q[25:21];
   assign rt_addr_o = instr_q[20:16];

   always_comb begin
      dec       = '0;
      dec.opsel = OPS_ZERO;
      case (op)
         6'h00: begin
            dec.opsel = OPS_RR;
            dec.wr    = 1'b1;
            dec.tgt   = instr_q[15:11];
            case (fn)
               6'h20: dec.ctrl = 5'd1;
               6'h21: dec.ctrl = 5'd2;
               6'h22: dec.ctrl = 5'd3;
               6'h24: dec.ctrl = 5'd4;
               6'h25: dec.ctrl = 5'd5;
               6'h26: dec.ctrl = 5'd6;
               6'h27: dec.ctrl = 5'd7;
               6'h28: dec.ctrl = 5'd8;
               6'h2A: dec.ctrl = 5'd9;
               6'h00: begin dec.ctrl = 5'd10; dec.opsel = OPS_SHAMT; end
               6'h02: begin dec.ctrl = 5'd11; dec.opsel = OPS_SHAMT; end
               6'h03: begin dec.ctrl = 5'd18; dec.opsel = OPS_SHAMT; end
               6'h08: begin dec.ctrl = 5'd12; dec.wr = 1'b0; dec.tgt = '0; end
               default: begin
                  dec         = '0;
                  dec.opsel   = OPS_ZERO;
                  dec.illegal = 1'b1;
               end
            endcase
         end
         6'h08, 6'h23, 6'h21, 6'h25, 6'h20, 6'h24: begin
            dec.ctrl = 5'd1; dec.opsel = OPS_RI; dec.wr = 1'b1; dec.tgt = instr_q[20:16];
         end
         6'h09: begin dec.ctrl = 5'd2;  dec.opsel = OPS_RI; dec.wr = 1'b1; dec.tgt = instr_q[20:16]; end
         6'h0F: begin dec.ctrl = 5'd17; dec.opsel = OPS_RI; dec.wr = 1'b1; dec.tgt = instr_q[20:16]; end
         6'h0C: begin dec.ctrl = 5'd20; dec.opsel = OPS_RI; dec.wr = 1'b1; dec.tgt = instr_q[20:16]; end
         6'h0D: begin dec.ctrl = 5'd19; dec.opsel = OPS_RI; dec.wr = 1'b1; dec.tgt = instr_q[20:16]; end
         6'h0E: begin dec.ctrl = 5'd21; dec.opsel = OPS_RI; dec.wr = 1'b1; dec.tgt = instr_q[20:16]; end
         6'h0A: begin dec.ctrl = 5'd9;  dec.opsel = OPS_RI; dec.wr = 1'b1; dec.tgt = instr_q[20:16]; end
         6'h2B, 6'h29, 6'h28: begin dec.ctrl = 5'd1; dec.opsel = OPS_RI; end
         6'h04: begin dec.ctrl = 5'd13; dec.opsel = OPS_RR; end
         6'h05: begin dec.ctrl = 5'd14; dec.opsel = OPS_RR; end
         6'h07: begin dec.ctrl = 5'd15; dec.opsel = OPS_RR; end
         6'h02: dec.ctrl = 5'd16;
         6'h03: begin dec.ctrl = 5'd16; dec.wr = 1'b1; dec.tgt = 5'd31; end
         6'h3F: dec.ctrl = 5'd0;
         default: dec.illegal = 1'b1;
      endcase
   end

   // Illegal instructions fall into OPS_ZERO so the ALU sees quiet operands.
   always_comb begin
      src1_d = '0;
      src2_d = '0;
      case (dec.opsel)
         OPS_SHAMT: begin src1_d = {{(DW-5){1'b0}}, instr_q[10:6]}; src2_d = rt_data_i; end
         OPS_RR:    begin src1_d = rs_data_i; src2_d = rt_data_i; end
         OPS_RI:    begin src1_d = rs_data_i; src2_d = {{(DW-16){instr_q[15]}}, instr_q[15:0]}; end
         default:   begin src1_d = '0; src2_d = '0; end
      endcase
   end

   assign wb_en_d  = dec.wr & (dec.tgt != 5'd0);
   assign w0_err_d = dec.wr & (dec.tgt == 5'd0) & (instr_q != 32'h0);

   assign out_valid_o = (state == DONE);
   assign in_ready_o  = (state == IDLE) | ((state == DONE) & out_ready_i);
   assign accept      = in_valid_i & in_ready_o;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid_i) state_nxt = DECODE;
         DECODE:  state_nxt = EXEC;
         EXEC:    state_nxt = DONE;
         DONE:    if (out_ready_i) state_nxt = in_valid_i ? DECODE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         instr_q    <= '0;
         alu_src1_o <= '0;
         alu_src2_o <= '0;
         alu_ctrl_o <= '0;
         res_o      <= '0;
         zero_o     <= 1'b0;
         ovf_o      <= 1'b0;
         wb_en_o    <= 1'b0;
         wb_addr_o  <= '0;
         w0_err_o   <= 1'b0;
         illegal_o  <= 1'b0;
         retired_o  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) instr_q <= instr_i;
         if (state == DECODE) begin
            alu_src1_o <= src1_d;
            alu_src2_o <= src2_d;
            alu_ctrl_o <= dec.ctrl;
         end
         // instr_q is still the in-flight instruction here, so the packet fields come straight from decode.
         if (state == EXEC) begin
            res_o     <= alu_result_i;
            zero_o    <= alu_zero_i;
            ovf_o     <= alu_err_i;
            wb_en_o   <= wb_en_d;
            wb_addr_o <= dec.tgt;
            w0_err_o  <= w0_err_d;
            illegal_o <= dec.illegal;
         end
         if ((state == DONE) && out_ready_i) retired_o <= retired_o + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized scoreboard bench for alu_issue_ctrl with a behavioural ALU and register file.
module tb_alu_issue_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        in_valid_i, in_ready_o;
   logic [31:0] instr_i;
   logic [4:0]  rs_addr_o, rt_addr_o;
   logic [31:0] rs_data_i, rt_data_i;
   logic [31:0] alu_src1_o, alu_src2_o, alu_result_i;
   logic [4:0]  alu_ctrl_o;
   logic        alu_zero_i, alu_err_i;
   logic        out_valid_o, out_ready_i;
   logic [31:0] res_o;
   logic        zero_o, ovf_o, wb_en_o, w0_err_o, illegal_o;
   logic [4:0]  wb_addr_o;
   logic [31:0] retired_o;

   alu_issue_ctrl #(.DW(32), .CNTW(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .instr_i(instr_i), .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o),
      .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
      .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
      .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i), .alu_err_i(alu_err_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .res_o(res_o), .zero_o(zero_o), .ovf_o(ovf_o), .wb_en_o(wb_en_o),
      .wb_addr_o(wb_addr_o), .w0_err_o(w0_err_o), .illegal_o(illegal_o), .retired_o(retired_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [4:0]  ctrl;
      logic [31:0] s1, s2, res;
      logic        zero, ovf, wb_en, w0, ill;
      logic [4:0]  wb_addr;
      int          acc;
   } exp_t;

   exp_t        q[$];
   exp_t        cur;
   bit          have_cur = 0;
   int          checks = 0, errors = 0, cyc = 0;
   logic [31:0] exp_retired = 0;
   bit          force_low = 0;
   logic [31:0] rf [32];
   logic [33:0] alu_bus;

   // Stand-in ALU: {result, zero, overflow}
   function automatic logic [33:0] alu_fn(logic [4:0] c, logic [31:0] a, logic [31:0] b);
      logic [31:0] r = 0;
      logic z, v = 0;
      case (c)
         5'd1:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
         5'd2:  r = a + b;
         5'd3:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
         5'd4:  r = a & b;
         5'd5:  r = a | b;
         5'd6:  r = a ^ b;
         5'd7:  r = ~(a | b);
         5'd8:  r = ~(a & b);
         5'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'd10: r = b << a[4:0];
         5'd11: r = b >> a[4:0];
         5'd18: r = 32'($signed(b) >>> a[4:0]);
         5'd12: r = a;
         5'd17: r = {b[15:0], 16'h0};
         5'd19: r = a | {16'h0, b[15:0]};
         5'd20: r = a & {16'h0, b[15:0]};
         5'd21: r = ~(a | {16'h0, b[15:0]});
         default: r = 0;
      endcase
      z = (r == 0);
      if (c == 5'd13) z = (a == b);
      if (c == 5'd14) z = (a != b);
      if (c == 5'd15) z = ($signed(a) > 0);
      return {r, z, v};
   endfunction

   assign alu_bus      = alu_fn(alu_ctrl_o, alu_src1_o, alu_src2_o);
   assign alu_result_i = alu_bus[33:2];
   assign alu_zero_i   = alu_bus[1];
   assign alu_err_i    = alu_bus[0];
   assign rs_data_i    = rf[rs_addr_o];
   assign rt_data_i    = rf[rt_addr_o];

   // Reference: operand class 0=none 1=shamt/rt 2=rs/rt 3=rs/imm; target -1 = no write.
   function automatic exp_t model(logic [31:0] ins, logic [31:0] a, logic [31:0] b);
      exp_t e;
      int   cls = 0, tgt = -1, ctrl = 0;
      bit   ill = 0;
      logic [5:0] op = ins[31:26];
      logic [5:0] fn = ins[5:0];
      if (op == 0) begin
         cls = 2; tgt = int'(ins[15:11]);
         case (fn)
            6'h20: ctrl = 1;  6'h21: ctrl = 2;  6'h22: ctrl = 3;  6'h24: ctrl = 4;
            6'h25: ctrl = 5;  6'h26: ctrl = 6;  6'h27: ctrl = 7;  6'h28: ctrl = 8;
            6'h2A: ctrl = 9;
            6'h00: begin ctrl = 10; cls = 1; end
            6'h02: begin ctrl = 11; cls = 1; end
            6'h03: begin ctrl = 18; cls = 1; end
            6'h08: begin ctrl = 12; tgt = -1; end
            default: begin ill = 1; cls = 0; tgt = -1; end
         endcase
      end else begin
         case (op)
            6'h08, 6'h23, 6'h21, 6'h25, 6'h20, 6'h24: begin ctrl = 1; cls = 3; tgt = int'(ins[20:16]); end
            6'h09: begin ctrl = 2;  cls = 3; tgt = int'(ins[20:16]); end
            6'h0F: begin ctrl = 17; cls = 3; tgt = int'(ins[20:16]); end
            6'h0C: begin ctrl = 20; cls = 3; tgt = int'(ins[20:16]); end
            6'h0D: begin ctrl = 19; cls = 3; tgt = int'(ins[20:16]); end
            6'h0E: begin ctrl = 21; cls = 3; tgt = int'(ins[20:16]); end
            6'h0A: begin ctrl = 9;  cls = 3; tgt = int'(ins[20:16]); end
            6'h2B, 6'h29, 6'h28: begin ctrl = 1; cls = 3; end
            6'h04: begin ctrl = 13; cls = 2; end
            6'h05: begin ctrl = 14; cls = 2; end
            6'h07: begin ctrl = 15; cls = 2; end
            6'h02: ctrl = 16;
            6'h03: begin ctrl = 16; tgt = 31; end
            6'h3F: ctrl = 0;
            default: ill = 1;
         endcase
      end
      e.ctrl = 5'(ctrl);
      case (cls)
         1: begin e.s1 = {27'h0, ins[10:6]}; e.s2 = b; end
         2: begin e.s1 = a; e.s2 = b; end
         3: begin e.s1 = a; e.s2 = {{16{ins[15]}}, ins[15:0]}; end
         default: begin e.s1 = 0; e.s2 = 0; end
      endcase
      {e.res, e.zero, e.ovf} = alu_fn(e.ctrl, e.s1, e.s2);
      e.wb_addr = (tgt >= 0) ? 5'(tgt) : 5'd0;
      e.wb_en   = (tgt > 0);
      e.w0      = (tgt == 0) && (ins != 0);
      e.ill     = ill;
      e.acc     = 0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic cmp_pkt(input string tag);
      chk({tag, "_ctrl"},    32'(alu_ctrl_o), 32'(cur.ctrl));
      chk({tag, "_src1"},    alu_src1_o,      cur.s1);
      chk({tag, "_src2"},    alu_src2_o,      cur.s2);
      chk({tag, "_res"},     res_o,           cur.res);
      chk({tag, "_zero"},    32'(zero_o),     32'(cur.zero));
      chk({tag, "_ovf"},     32'(ovf_o),      32'(cur.ovf));
      chk({tag, "_wb_en"},   32'(wb_en_o),    32'(cur.wb_en));
      chk({tag, "_wb_addr"}, 32'(wb_addr_o),  32'(cur.wb_addr));
      chk({tag, "_w0_err"},  32'(w0_err_o),   32'(cur.w0));
      chk({tag, "_illegal"}, 32'(illegal_o),  32'(cur.ill));
      chk({tag, "_retired"}, retired_o,       exp_retired);
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   initial begin
      out_ready_i = 1'b0;
      forever begin
         @(posedge clk_i); #1;
         out_ready_i = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: first valid cycle pops the scoreboard, later stall cycles check stability.
   always @(negedge clk_i) begin
      if (rst_i) have_cur = 0;
      else if (out_valid_o) begin
         if (!have_cur) begin
            if (q.size() == 0) chk("unexpected_valid", 32'(out_valid_o), 32'd0);
            else begin
               cur = q.pop_front();
               have_cur = 1;
               chk("latency", 32'(cyc - cur.acc), 32'd3);
               cmp_pkt("pkt");
            end
         end else cmp_pkt("hold");
         chk("in_ready_done", 32'(in_ready_o), 32'(out_ready_i));
         if (have_cur && out_ready_i) begin
            exp_retired = exp_retired + 1;
            have_cur = 0;
         end
      end
   end

   task automatic issue(input logic [31:0] ins, input logic [31:0] rsv, input logic [31:0] rtv);
      exp_t e;
      @(posedge clk_i); #1;
      in_valid_i = 1'b1;
      instr_i    = ins;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk_i);
         if (in_ready_o) begin
            if (ins[25:21] != 0) rf[ins[25:21]] = rsv;
            if (ins[20:16] != 0) rf[ins[20:16]] = rtv;
            e = model(ins, rf[ins[25:21]], rf[ins[20:16]]);
            e.acc = cyc;
            q.push_back(e);
            @(posedge clk_i); #1;
            in_valid_i = 1'b0;
            return;
         end
      end
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid_i = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 500; t++) begin
         @(negedge clk_i);
         if (q.size() == 0 && !have_cur && !out_valid_o) return;
      end
      chk("drain_timeout", 32'd0, 32'd1);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] rops [22] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h28,
                                6'h2A, 6'h00, 6'h02, 6'h03, 6'h08, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
      logic [5:0] iops [22] = '{6'h08, 6'h09, 6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2B,
                                6'h29, 6'h28, 6'h0F, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h04,
                                6'h05, 6'h07, 6'h02, 6'h03, 6'h3F, 6'h08};
      logic [31:0] w = $urandom;
      int sel = $urandom_range(0, 9);
      if (sel <= 3) begin
         w[31:26] = 6'h00;
         w[5:0]   = ($urandom_range(0, 15) == 0) ? 6'($urandom) : rops[$urandom_range(0, 12)];
      end else if (sel <= 7) w[31:26] = iops[$urandom_range(0, 21)];
      else if (sel == 8) w[31:26] = 6'($urandom);
      else w = 32'h0;
      if ($urandom_range(0, 7) == 0) w[15:11] = 5'd0;
      if ($urandom_range(0, 7) == 0) w[20:16] = 5'd0;
      return w;
   endfunction

   initial begin
      bit seen;
      logic [31:0] a;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      rst_i = 1'b1; in_valid_i = 1'b0; instr_i = 32'h0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_in_ready",  32'(in_ready_o),  32'd1);
      chk("rst_retired",   retired_o,        32'd0);
      chk("rst_res",       res_o,            32'd0);
      chk("rst_ctrl",      32'(alu_ctrl_o),  32'd0);
      chk("rst_flags",     32'({wb_en_o, w0_err_o, illegal_o, zero_o, ovf_o}), 32'd0);
      @(posedge clk_i); #1 rst_i = 1'b0;

      issue(32'h00221820, 32'h7FFFFFFF, 32'h1);   // add $3,$1,$2 overflow
      issue(32'h2005FFFF, 32'h0, 32'h1234);       // addi $5,$0,-1
      issue(32'h000220C0, 32'h0, 32'd5);          // sll $4,$2,3
      issue(32'h00000000, 32'h0, 32'h0);          // NOP
      issue(32'h10220004, 32'd7, 32'd7);          // beq taken
      issue(32'h00220020, 32'd9, 32'd4);          // add $0 -> w0_err
      drain();

      force_low = 1;
      issue(32'hF8000000, 32'h0, 32'h0);          // illegal opcode 0x3E, stalled
      seen = 0;
      for (int t = 0; t < 50 && !seen; t++) begin
         @(negedge clk_i);
         seen = out_valid_o;
      end
      chk("stall_valid_seen", 32'(seen), 32'd1);
      repeat (5) @(negedge clk_i);
      force_low = 0;
      drain();

      issue(32'h00221820, 32'h11111111, 32'h22222222);
      @(posedge clk_i); #1 rst_i = 1'b1;         // lands on the EXEC edge
      @(posedge clk_i); #1 rst_i = 1'b0;
      q.delete();
      exp_retired = 0;
      @(negedge clk_i);
      chk("abort_out_valid", 32'(out_valid_o), 32'd0);
      chk("abort_retired",   retired_o,        32'd0);
      chk("abort_in_ready",  32'(in_ready_o),  32'd1);
      issue(32'h00221822, 32'd10, 32'd3);         // sub after abort
      drain();

      for (int n = 0; n < 300; n++) begin
         a = $urandom;
         issue(rand_instr(), a, ($urandom_range(0, 3) == 0) ? a : $urandom);
      end
      drain();
      chk("final_retired", retired_o, exp_retired);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
